pe_input_skew_feeder: RTL and testbench

Upstream edge feeder for a systolic column of `PE_unit` instances. It accepts one ROWS-wide input vector per handshake from the activation buffer. It applies the triangular skew required by the array, delaying lane i by i cycles, and drives each row's `input_2` with zero-filled bubbles. It sequences a K-beat job through start / stream / drain and flags completion when the last skewed element leaves the feeder.

---
 rtl/pe_input_skew_feeder.sv | 75 +++++++
 tb/tb_pe_input_skew_feeder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pe_input_skew_feeder.sv
// pe_input_skew_feeder: sequences a K-beat job and feeds a systolic column with a triangular lane skew.
module pe_input_skew_feeder #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LEN_WIDTH-1:0]       len,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_valid
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [LEN_WIDTH-1:0] k, cnt, drain_cnt;
    logic acc;
    assign in_ready = (state == STREAM) && (cnt != k);
    assign acc      = in_valid & in_ready;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    // DONE doubles as the completion cycle for every job, keeping busy high through it
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? DONE : STREAM;
            STREAM:  if (acc && cnt == k - LEN_WIDTH'(1)) state_nx = (ROWS == 1) ? DONE : DRAIN;
            DRAIN:   if (drain_cnt == LEN_WIDTH'(ROWS - 2)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                k   <= len;
                cnt <= '0;
            end else if (acc) begin
                cnt <= cnt + LEN_WIDTH'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + LEN_WIDTH'(1) : '0;
        end
    end
    for (genvar g = 0; g < ROWS; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] d [g+1];
        logic                  v [g+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= g; j++) begin
                    d[j] <= '0;
                    v[j] <= 1'b0;
                end
            end else begin
                d[0] <= acc ? in_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
                v[0] <= acc;
                for (int j = 1; j <= g; j++) begin
                    d[j] <= d[j-1];
                    v[j] <= v[j-1];
                end
            end
        end
        assign out_valid[g]                         = v[g];
        assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = v[g] ? d[g] : '0;
    end
endmodule

// File: tb/tb_pe_input_skew_feeder.sv
// tb_pe_input_skew_feeder: directed per-cycle vectors for ROWS=4 plus hand sequences for reset and ROWS=1.
module tb_pe_input_skew_feeder;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 0, in_valid = 0;
    logic [15:0] len = '0;
    logic [63:0] in_data = '0;
    logic        busy, done, in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_valid;
    logic        st1 = 0, iv1 = 0;
    logic [15:0] len1 = '0, id1 = '0;
    logic        busy1, done1, rdy1;
    logic [15:0] od1;
    logic [0:0]  ov1;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    pe_input_skew_feeder #(.ROWS(4), .DATA_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid));

    pe_input_skew_feeder #(.ROWS(1), .DATA_WIDTH(16), .LEN_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .len(len1), .busy(busy1), .done(done1),
        .in_valid(iv1), .in_ready(rdy1), .in_data(id1),
        .out_data(od1), .out_valid(ov1));

    typedef struct {
        logic        st;
        logic [15:0] ln;
        logic        iv;
        logic [63:0] id;
        logic        bz, dn, rd;
        logic [3:0]  ov;
        logic [63:0] od;
    } vec_t;

    vec_t tv [64];
    int   n = 0;

    function automatic vec_t r(logic st, logic [15:0] ln, logic iv, int b,
                               logic bz, logic dn, logic rd, logic [3:0] ov, logic [63:0] od);
        vec_t x;
        logic [15:0] w;
        w = 16'(b) * 16'h0101;
        x.st = st; x.ln = ln; x.iv = iv; x.id = {w, w, w, w};
        x.bz = bz; x.dn = dn; x.rd = rd; x.ov = ov; x.od = od;
        return x;
    endfunction

    task automatic add(input vec_t x);
        tv[n] = x;
        n++;
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic run_row(input vec_t v, input int idx);
        @(negedge clk);
        start = v.st; len = v.ln; in_valid = v.iv; in_data = v.id;
        #1;
        chk($sformatf("busy[%0d]", idx), 64'(busy), 64'(v.bz));
        chk($sformatf("done[%0d]", idx), 64'(done), 64'(v.dn));
        chk($sformatf("in_ready[%0d]", idx), 64'(in_ready), 64'(v.rd));
        chk($sformatf("out_valid[%0d]", idx), 64'(out_valid), 64'(v.ov));
        chk($sformatf("out_data[%0d]", idx), out_data, v.od);
    endtask

    task automatic add_basic();
        add(r(1, 3, 1, 1, 0, 0, 0, 4'b0000, 64'h0));
        add(r(0, 0, 1, 1, 1, 0, 1, 4'b0000, 64'h0));
        add(r(0, 0, 1, 2, 1, 0, 1, 4'b0001, 64'h0000_0000_0000_0101));
        add(r(0, 0, 1, 3, 1, 0, 1, 4'b0011, 64'h0000_0000_0101_0202));
        add(r(0, 0, 1, 0, 1, 0, 0, 4'b0111, 64'h0000_0101_0202_0303));
        add(r(0, 0, 1, 0, 1, 0, 0, 4'b1110, 64'h0101_0202_0303_0000));
        add(r(0, 0, 1, 0, 1, 0, 0, 4'b1100, 64'h0202_0303_0000_0000));
        add(r(0, 0, 1, 0, 1, 1, 0, 4'b1000, 64'h0303_0000_0000_0000));
        add(r(0, 0, 1, 0, 0, 0, 0, 4'b0000, 64'h0));
    endtask

    initial begin
        int base;
        add_basic();
        // one-cycle upstream bubble after beat 1
        add(r(1, 3, 1, 1, 0, 0, 0, 4'b0000, 64'h0));
        add(r(0, 0, 1, 1, 1, 0, 1, 4'b0000, 64'h0));
        add(r(0, 0, 0, 2, 1, 0, 1, 4'b0001, 64'h0000_0000_0000_0101));
        add(r(0, 0, 1, 2, 1, 0, 1, 4'b0010, 64'h0000_0000_0101_0000));
        add(r(0, 0, 1, 3, 1, 0, 1, 4'b0101, 64'h0000_0101_0000_0202));
        add(r(0, 0, 1, 0, 1, 0, 0, 4'b1011, 64'h0101_0000_0202_0303));
        add(r(0, 0, 1, 0, 1, 0, 0, 4'b0110, 64'h0000_0202_0303_0000));
        add(r(0, 0, 1, 0, 1, 0, 0, 4'b1100, 64'h0202_0303_0000_0000));
        add(r(0, 0, 1, 0, 1, 1, 0, 4'b1000, 64'h0303_0000_0000_0000));
        add(r(0, 0, 1, 0, 0, 0, 0, 4'b0000, 64'h0));
        // zero-length job
        add(r(1, 0, 1, 1, 0, 0, 0, 4'b0000, 64'h0));
        add(r(0, 0, 1, 1, 1, 1, 0, 4'b0000, 64'h0));
        add(r(0, 0, 1, 1, 0, 0, 0, 4'b0000, 64'h0));
        // start pulses while busy (mid-stream and in the done cycle) must be ignored
        base = n;
        add_basic();
        tv[base+2].st = 1; tv[base+2].ln = 16'd1;
        tv[base+7].st = 1; tv[base+7].ln = 16'd2;
        add(r(0, 0, 1, 0, 0, 0, 0, 4'b0000, 64'h0));

        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h0);
        chk("rst_ov", 64'(out_valid), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < n; i++) run_row(tv[i], i);

        // reset asserted in DRAIN while lanes 1..3 hold data
        for (int i = 0; i < 6; i++) run_row(tv[i], 100 + i);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_done", 64'(done), 64'h0);
        chk("arst_ready", 64'(in_ready), 64'h0);
        chk("arst_ov", 64'(out_valid), 64'h0);
        chk("arst_od", out_data, 64'h0);
        @(negedge clk);
        chk("arst_hold_ov", 64'(out_valid), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) run_row(r(0, 0, 0, 0, 0, 0, 0, 4'b0000, 64'h0), 200 + i);
        for (int i = 0; i < 9; i++) run_row(tv[i], 300 + i);

        // single-row feeder, K=2: no drain, done with the second output beat
        @(negedge clk); st1 = 1; len1 = 16'd2; iv1 = 1; id1 = 16'h00AA; #1;
        chk("r1_c0_busy", 64'(busy1), 64'h0);
        @(negedge clk); st1 = 0; id1 = 16'h00AA; #1;
        chk("r1_c1_ready", 64'(rdy1), 64'h1);
        chk("r1_c1_ov", 64'(ov1), 64'h0);
        @(negedge clk); id1 = 16'h00BB; #1;
        chk("r1_c2_ready", 64'(rdy1), 64'h1);
        chk("r1_c2_ov", 64'(ov1), 64'h1);
        chk("r1_c2_od", 64'(od1), 64'h00AA);
        chk("r1_c2_done", 64'(done1), 64'h0);
        @(negedge clk); id1 = 16'h00CC; #1;
        chk("r1_c3_ready", 64'(rdy1), 64'h0);
        chk("r1_c3_ov", 64'(ov1), 64'h1);
        chk("r1_c3_od", 64'(od1), 64'h00BB);
        chk("r1_c3_done", 64'(done1), 64'h1);
        @(negedge clk); iv1 = 0; #1;
        chk("r1_c4_busy", 64'(busy1), 64'h0);
        chk("r1_c4_ov", 64'(ov1), 64'h0);
        chk("r1_c4_done", 64'(done1), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
